// File: rtl/passcode_entry_pkg.sv
// Shared types and constants for the alarm keypad slice.
//   fsm_state_t : alarm state machine encoding (consumed by passcode_entry)
//   pe_state_t  : internal states of passcode_entry
//   CLK_HZ      : system clock frequency
//   is_bcd()    : true for a valid decimal digit 0..9
package passcode_entry_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  typedef enum logic [1:0] {
    PE_ENTER,
    PE_CHECK,
    PE_LOCK
  } pe_state_t;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/passcode_entry_btn_edge.sv
// Raw active-low push button -> one-cycle press strobe.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   btn_n_i : raw button, active-low, asynchronous to clk
//   fall_o  : high for one cycle per high-to-low transition; a press
//             registers in the consumer on the 3rd edge after the raw
//             input is first sampled low
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic fall_o
);

  logic       sync1_q, sync2_q;
  logic [1:0] fill_q;
  logic       high_q;

  // high_q only becomes 1 once the synchroniser holds a level really
  // sampled from the pin (fill_q[1]) and that level was high. The reset
  // value 1 of the synchroniser therefore never counts as "released",
  // so a button held through reset produces no press on reset exit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= '0;
      high_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      high_q  <= fill_q[1] & sync2_q;
    end
  end

  assign fall_o = high_q & ~sync2_q;

endmodule

// File: rtl/passcode_entry.sv
// Keypad passcode collector and checker for the alarm state machine.
//   clk, rst          : 50 MHz clock, synchronous active-low reset
//   system_state      : alarm state; input accepted in SET/TRIGGER only
//   sw                : BCD digit, sampled on a digit press
//   btn_digit/clear   : raw active-low buttons (enter digit / discard entry)
//   passcode_correct  : one-cycle pulse on matching entry
//   passcode_wrong    : one-cycle pulse on mismatching entry
//   digits_entered    : digits currently buffered (0..DIGITS)
//   entry_buf         : buffered digits, newest in [3:0]
//   fail_count        : consecutive failures
//   locked            : high during lockout
module passcode_entry
  import passcode_entry_pkg::*;
#(
  parameter int unsigned         DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] CODE        = 16'h3216,
  parameter int unsigned         MAX_FAIL    = 3,
  parameter int unsigned         LOCK_CYCLES = 5 * CLK_HZ
) (
  input  logic                clk,
  input  logic                rst,
  input  fsm_state_t          system_state,
  input  logic [3:0]          sw,
  input  logic                btn_digit,
  input  logic                btn_clear,
  output logic                passcode_correct,
  output logic                passcode_wrong,
  output logic [3:0]          digits_entered,
  output logic [4*DIGITS-1:0] entry_buf,
  output logic [2:0]          fail_count,
  output logic                locked
);

  localparam int unsigned W         = 4 * DIGITS;
  localparam logic [3:0]  FULL      = 4'(DIGITS);
  localparam logic [2:0]  MAXF      = 3'(MAX_FAIL);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);

  logic digit_press, clear_press;

  btn_edge u_btn_digit (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_digit),
    .fall_o  (digit_press)
  );

  btn_edge u_btn_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_clear),
    .fall_o  (clear_press)
  );

  pe_state_t     state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    fail_q, fail_d;
  logic [31:0]   lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PE_ENTER;
      buf_q      <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;

    case (system_state)
      STATE_IDLE: begin
        state_d    = PE_ENTER;
        buf_d      = '0;
        cnt_d      = '0;
        fail_d     = '0;
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
      STATE_ALERT: begin
        // everything holds; result pulses forced low by the defaults
      end
      default: begin
        case (state_q)
          PE_ENTER: begin
            // a full buffer moves on one cycle after the last digit lands,
            // so presses in that cycle cannot overfill it
            if (cnt_q == FULL) begin
              state_d = PE_CHECK;
            end else if (clear_press) begin
              buf_d = '0;
              cnt_d = '0;
            end else if (digit_press && is_bcd(sw)) begin
              buf_d = {buf_q[W-5:0], sw};
              cnt_d = cnt_q + 4'd1;
            end
          end
          PE_CHECK: begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = PE_ENTER;
            if (buf_q == CODE) begin
              correct_d = 1'b1;
              fail_d    = '0;
            end else begin
              wrong_d = 1'b1;
              if (fail_q < MAXF) fail_d = fail_q + 3'd1;
              if (fail_d == MAXF) begin
                state_d    = PE_LOCK;
                locked_d   = 1'b1;
                lock_cnt_d = '0;
              end
            end
          end
          PE_LOCK: begin
            if (lock_cnt_q == LOCK_LAST) begin
              state_d    = PE_ENTER;
              locked_d   = 1'b0;
              fail_d     = '0;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 32'd1;
            end
          end
          default: state_d = PE_ENTER;
        endcase
      end
    endcase
  end

  assign passcode_correct = correct_q;
  assign passcode_wrong   = wrong_q;
  assign digits_entered   = cnt_q;
  assign entry_buf        = buf_q;
  assign fail_count       = fail_q;
  assign locked           = locked_q;

endmodule

// File: tb/tb_passcode_entry.sv
module tb_passcode_entry;
  import passcode_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  fsm_state_t  system_state;
  logic [3:0]  sw;
  logic        btn_digit, btn_clear;
  logic        passcode_correct, passcode_wrong;
  logic [3:0]  digits_entered;
  logic [15:0] entry_buf;
  logic [2:0]  fail_count;
  logic        locked;

  passcode_entry #(
    .DIGITS      (4),
    .CODE        (16'h3216),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .system_state     (system_state),
    .sw               (sw),
    .btn_digit        (btn_digit),
    .btn_clear        (btn_clear),
    .passcode_correct (passcode_correct),
    .passcode_wrong   (passcode_wrong),
    .digits_entered   (digits_entered),
    .entry_buf        (entry_buf),
    .fail_count       (fail_count),
    .locked           (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lock_cycles = 0;

  typedef struct packed {
    logic       correct;
    logic [2:0] fail;
    logic       locked;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    fsm_state_t st;
    logic [15:0] code;
    logic        correct;
    logic [2:0]  fail;
    logic        locked;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every result pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst && (passcode_correct || passcode_wrong)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, passcode_correct, passcode_wrong}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_correct", passcode_correct, e.correct);
        chk("sb_wrong", passcode_wrong, !e.correct);
        chk("sb_fail_count", fail_count, e.fail);
        chk("sb_locked", locked, e.locked);
      end
    end
    if (locked) lock_cycles++;
  end

  task automatic press_digit(input logic [3:0] d);
    sw = d;
    btn_digit = 1'b0;
    repeat (4) @(negedge clk);
    btn_digit = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_clear();
    btn_clear = 1'b0;
    repeat (4) @(negedge clk);
    btn_clear = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press_digit(c[4*i +: 4]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;

    tbl[0] = '{STATE_SET,     16'h3216, 1'b1, 3'd0, 1'b0};
    tbl[1] = '{STATE_TRIGGER, 16'h1234, 1'b0, 3'd1, 1'b0};
    tbl[2] = '{STATE_TRIGGER, 16'h3216, 1'b1, 3'd0, 1'b0};
    tbl[3] = '{STATE_SET,     16'h0000, 1'b0, 3'd1, 1'b0};
    tbl[4] = '{STATE_SET,     16'h9999, 1'b0, 3'd2, 1'b0};
    tbl[5] = '{STATE_TRIGGER, 16'h3216, 1'b1, 3'd0, 1'b0};
    tbl[6] = '{STATE_TRIGGER, 16'h1234, 1'b0, 3'd1, 1'b0};
    tbl[7] = '{STATE_TRIGGER, 16'h1234, 1'b0, 3'd2, 1'b0};
    tbl[8] = '{STATE_TRIGGER, 16'h1234, 1'b0, 3'd3, 1'b1};

    rst = 1'b0;
    system_state = STATE_IDLE;
    sw = 4'd0;
    btn_digit = 1'b1;
    btn_clear = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_correct", passcode_correct, 0);
    chk("rst_wrong", passcode_wrong, 0);
    chk("rst_digits", digits_entered, 0);
    chk("rst_buf", entry_buf, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    system_state = STATE_SET;
    @(negedge clk);

    // exact latency of the result pulse after the last digit lands
    press_digit(4'd3);
    press_digit(4'd2);
    press_digit(4'd1);
    sb.push_back('{1'b1, 3'd0, 1'b0});
    sw = 4'd6;
    btn_digit = 1'b0;
    n = 0;
    while (digits_entered != 4'd4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("press_latency", n, 3);
    chk("buf_full", entry_buf, 16'h3216);
    btn_digit = 1'b1;
    m = 0;
    while (!passcode_correct && m < 10) begin
      @(negedge clk);
      m++;
    end
    chk("result_latency", m, 2);
    chk("digits_cleared", digits_entered, 0);
    chk("buf_cleared", entry_buf, 0);
    @(negedge clk);
    chk("pulse_one_cycle", passcode_correct, 0);
    repeat (3) @(negedge clk);
    wait_drain("drain_first");

    lock_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      system_state = tbl[i].st;
      @(negedge clk);
      sb.push_back('{tbl[i].correct, tbl[i].fail, tbl[i].locked});
      enter_code(tbl[i].code);
      wait_drain($sformatf("drain_vec%0d", i));
    end
    n = 0;
    while (locked && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("lock_released", locked, 0);
    chk("lock_duration", lock_cycles, 100);
    chk("fail_after_lock", fail_count, 0);

    // lockout aborted by IDLE
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{1'b0, 3'(i), (i == 3)});
      enter_code(16'h1234);
      wait_drain("drain_lock2");
    end
    repeat (10) @(negedge clk);
    chk("mid_lock_locked", locked, 1);
    system_state = STATE_IDLE;
    @(negedge clk);
    chk("idle_unlocks", locked, 0);
    chk("idle_fail_zero", fail_count, 0);
    system_state = STATE_SET;
    @(negedge clk);

    // clear discards a partial entry
    press_digit(4'd3);
    press_digit(4'd2);
    press_clear();
    chk("clear_digits", digits_entered, 0);
    sb.push_back('{1'b1, 3'd0, 1'b0});
    enter_code(16'h3216);
    wait_drain("drain_after_clear");

    // non-decimal digit ignored
    press_digit(4'd5);
    press_digit(4'd12);
    chk("sw12_digits", digits_entered, 1);
    chk("sw12_buf", entry_buf, 16'h0005);
    press_clear();

    // long hold gives a single digit
    sw = 4'd7;
    btn_digit = 1'b0;
    repeat (50) @(negedge clk);
    btn_digit = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_digits", digits_entered, 1);
    chk("hold_buf", entry_buf, 16'h0007);

    // simultaneous clear and digit: clear wins
    sw = 4'd4;
    btn_digit = 1'b0;
    btn_clear = 1'b0;
    repeat (4) @(negedge clk);
    btn_digit = 1'b1;
    btn_clear = 1'b1;
    repeat (3) @(negedge clk);
    chk("clear_wins", digits_entered, 0);

    // ALERT freezes the partial entry
    press_digit(4'd3);
    press_digit(4'd2);
    system_state = STATE_ALERT;
    @(negedge clk);
    enter_code(16'h1699);
    chk("alert_digits", digits_entered, 2);
    chk("alert_buf", entry_buf, 16'h0032);
    system_state = STATE_SET;
    @(negedge clk);
    sb.push_back('{1'b1, 3'd0, 1'b0});
    press_digit(4'd1);
    press_digit(4'd6);
    wait_drain("drain_after_alert");

    // reset mid-entry
    sb.push_back('{1'b0, 3'd1, 1'b0});
    enter_code(16'h1111);
    wait_drain("drain_before_reset");
    press_digit(4'd4);
    press_digit(4'd5);
    chk("pre_reset_digits", digits_entered, 2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_digits", digits_entered, 0);
    chk("mid_rst_buf", entry_buf, 0);
    chk("mid_rst_fail", fail_count, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_pulses", {passcode_correct, passcode_wrong}, 0);

    // button held through reset
    sw = 4'd8;
    btn_digit = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_rst_no_press", digits_entered, 0);
    btn_digit = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_rst_release", digits_entered, 0);
    press_digit(4'd8);
    chk("press_after_rst", digits_entered, 1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
